// File: rtl/gate_exhaustive_tester_pkg.sv
// Shared types and truth-table constants for the exhaustive gate tester.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit k is the expected gate output for input vector k (A is the vector MSB).
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_exhaustive_tester_if.sv
// Bundle between the tester (master) and the gate/stimulus side (slave).
interface gate_exhaustive_tester_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic             start;
  logic             abort;
  logic             y_in;
  logic [N_IN-1:0]  vec_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [N_IN-1:0]  first_fail;

  modport master (
    input  start, abort, y_in,
    output vec_out, busy, done, pass, err_count, first_fail
  );

  modport slave (
    output start, abort, y_in,
    input  vec_out, busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/gate_exhaustive_tester.sv
// Walks every input vector of a small combinational gate in ascending order,
// holds each for SETTLE cycles, compares the gate output with TRUTH and
// reports verdict, saturating mismatch count and first failing vector.
module gate_exhaustive_tester
  import gate_test_pkg::*;
#(
  parameter int               N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH = TT_AND2,
  parameter int               SETTLE = 2,
  parameter int               ERR_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gate_exhaustive_tester_if.master bus
);

  // One extra index bit keeps the terminal compare from wrapping.
  localparam int               IDX_W    = N_IN + 1;
  localparam int               SET_W    = $clog2(SETTLE + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << N_IN) - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [SET_W-1:0] settle_q;
  logic [N_IN-1:0]  vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [N_IN-1:0]  ff_q;
  logic [N_IN-1:0]  ff_d;
  logic             mismatch;

  // Saturating increment of the mismatch counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

  // Result of the sample that would be taken at the end of the current window.
  always_comb begin
    mismatch = (bus.y_in != TRUTH[idx_q[N_IN-1:0]]);
    err_d    = err_q;
    ff_d     = ff_q;
    idx_d    = idx_q + 1'b1;
    if (mismatch) begin
      if (err_q == '0) ff_d = idx_q[N_IN-1:0];
      err_d = sat_inc(err_q);
    end
  end

  // Sequencer FSM; every output is a register so the gate sees clean inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ff_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          vec_q  <= '0;
          busy_q <= 1'b0;
          if (bus.start) begin
            state_q  <= APPLY;
            idx_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b1;
            err_q    <= '0;
            ff_q     <= '0;
            pass_q   <= 1'b0;
          end
        end
        APPLY: begin
          if (bus.abort) begin
            // Cancel wins over a sample on the same edge; partial results stay.
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
          end else if (settle_q == SET_LAST) begin
            err_q <= err_d;
            ff_q  <= ff_d;
            if (idx_q == IDX_LAST) begin
              // Verdict includes the final sample, so it is valid with done.
              state_q <= DONE;
              vec_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              idx_q    <= idx_d;
              vec_q    <= idx_d[N_IN-1:0];
              settle_q <= '0;
            end
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vec_out    = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_gate_exhaustive_tester.sv
// Bench for gate_exhaustive_tester: real gate primitives with injectable
// faults feed the tester; a truth-table model predicts verdict and counts.
module tb_gate_exhaustive_tester;

  localparam logic [3:0] TRUTH0 = gate_test_pkg::TT_AND2;
  localparam logic [7:0] TRUTH2 = 8'b1001_0110; // 3-input parity

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  gate_exhaustive_tester_if #(.N_IN(2), .ERR_W(8)) if0 ();
  gate_exhaustive_tester_if #(.N_IN(2), .ERR_W(1)) if1 ();
  gate_exhaustive_tester_if #(.N_IN(3), .ERR_W(8)) if2 ();

  gate_exhaustive_tester #(.N_IN(2), .TRUTH(TRUTH0), .SETTLE(2), .ERR_W(8))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  gate_exhaustive_tester #(.N_IN(2), .TRUTH(gate_test_pkg::TT_OR2), .SETTLE(2), .ERR_W(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  gate_exhaustive_tester #(.N_IN(3), .TRUTH(TRUTH2), .SETTLE(3), .ERR_W(8))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Gate-level devices under test for u0, selectable, with per-vector fault flips.
  logic w_and, w_or, w_xor, w_nand, w_nor, gy;
  int         sel0  = 0;
  logic [3:0] flip0 = 4'b0;
  logic [7:0] flip2 = 8'b0;

  and  g_and  (w_and,  if0.vec_out[1], if0.vec_out[0]);
  or   g_or   (w_or,   if0.vec_out[1], if0.vec_out[0]);
  xor  g_xor  (w_xor,  if0.vec_out[1], if0.vec_out[0]);
  nand g_nand (w_nand, if0.vec_out[1], if0.vec_out[0]);
  nor  g_nor  (w_nor,  if0.vec_out[1], if0.vec_out[0]);

  always_comb begin
    gy = w_and;
    case (sel0)
      1: gy = w_or;
      2: gy = w_xor;
      3: gy = w_nand;
      4: gy = w_nor;
      default: gy = w_and;
    endcase
  end

  assign if0.y_in = gy ^ flip0[if0.vec_out];
  assign if1.y_in = 1'b0;
  assign if2.y_in = (^if2.vec_out) ^ flip2[if2.vec_out];

  function automatic logic [3:0] tt_of(input int sel);
    case (sel)
      1: return gate_test_pkg::TT_OR2;
      2: return gate_test_pkg::TT_XOR2;
      3: return gate_test_pkg::TT_NAND2;
      4: return gate_test_pkg::TT_NOR2;
      default: return gate_test_pkg::TT_AND2;
    endcase
  endfunction

  // Reference: count disagreements over the whole table, clip to counter range.
  function automatic void model(input int nvec, input logic [15:0] truth,
                                input logic [15:0] yv, input int errw,
                                output int errs, output int first, output bit ok);
    int raw = 0;
    first = -1;
    for (int k = 0; k < nvec; k++) begin
      if (yv[k] != truth[k]) begin
        raw++;
        if (first < 0) first = k;
      end
    end
    ok   = (raw == 0);
    errs = (raw > (1 << errw) - 1) ? (1 << errw) - 1 : raw;
    if (first < 0) first = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run on u0; caller is 1 time unit after an edge with u0 idle.
  task automatic run_u0(input int sel, input logic [3:0] flip, input bit poke);
    int errs, first;
    bit ok;
    logic [3:0] yv;
    sel0  = sel;
    flip0 = flip;
    yv    = tt_of(sel) ^ flip;
    model(4, 16'(TRUTH0), 16'(yv), 8, errs, first, ok);
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (poke) if0.start = (c == 3 || c == 6);
      n_tests++;
      if ({if0.busy, if0.done, if0.vec_out} !== {1'b1, 1'b0, 2'((c - 1) / 2)}) begin
        n_fail++;
        $display("FAIL run_vec c=%0d: busy,done,vec=%b required %b", c,
                 {if0.busy, if0.done, if0.vec_out}, {1'b1, 1'b0, 2'((c - 1) / 2)});
      end
      tick();
    end
    if0.start = 1'b0;
    n_tests++;
    if ({if0.busy, if0.done, if0.vec_out} !== 4'b0100) begin
      n_fail++;
      $display("FAIL run_done: busy,done,vec=%b required 0100", {if0.busy, if0.done, if0.vec_out});
    end
    n_tests++;
    if (if0.pass !== ok) begin
      n_fail++;
      $display("FAIL run_pass sel=%0d flip=%b: got %b required %b", sel, flip, if0.pass, ok);
    end
    n_tests++;
    if (if0.err_count !== 8'(errs)) begin
      n_fail++;
      $display("FAIL run_err sel=%0d flip=%b: got %0d required %0d", sel, flip, if0.err_count, errs);
    end
    if (errs != 0) begin
      n_tests++;
      if (if0.first_fail !== 2'(first)) begin
        n_fail++;
        $display("FAIL run_first sel=%0d flip=%b: got %0d required %0d", sel, flip, if0.first_fail, first);
      end
    end
    tick();
    n_tests++;
    if ({if0.busy, if0.done, if0.pass} !== {1'b0, 1'b0, ok}) begin
      n_fail++;
      $display("FAIL run_after: busy,done,pass=%b required %b", {if0.busy, if0.done, if0.pass}, {1'b0, 1'b0, ok});
    end
  endtask

  task automatic test_reset();
    if0.start = 0; if0.abort = 0;
    if1.start = 0; if1.abort = 0;
    if2.start = 0; if2.abort = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({if0.busy, if0.done, if0.pass, if0.err_count, if0.first_fail, if0.vec_out} !== '0 ||
        {if2.busy, if2.done, if2.pass, if2.err_count, if2.first_fail, if2.vec_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: u0 err=%0d vec=%b busy=%b, required all zero",
               if0.err_count, if0.vec_out, if0.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_and();
    run_u0(0, 4'b0000, 1'b0);
  endtask

  task automatic test_or_mismatch();
    run_u0(1, 4'b0000, 1'b0);
    n_tests++;
    if ({if0.err_count, if0.first_fail, if0.pass} !== {8'd2, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL or_fixed: err=%0d first=%0d pass=%b required 2 1 0",
               if0.err_count, if0.first_fail, if0.pass);
    end
  endtask

  task automatic test_abort();
    bit seen_done = 0;
    sel0 = 0;
    flip0 = 4'b0110; // vectors 1 and 2 disagree
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    repeat (5) tick(); // cycle 6: last cycle of vector 2
    n_tests++;
    if (if0.vec_out !== 2'd2) begin
      n_fail++;
      $display("FAIL abort_pre_vec: got %0d required 2", if0.vec_out);
    end
    if0.abort = 1'b1;
    tick();
    if0.abort = 1'b0;
    n_tests++;
    if ({if0.busy, if0.vec_out, if0.done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_idle: busy,vec,done=%b required 0000", {if0.busy, if0.vec_out, if0.done});
    end
    n_tests++;
    if ({if0.err_count, if0.first_fail, if0.pass} !== {8'd1, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_partial: err=%0d first=%0d pass=%b required 1 1 0",
               if0.err_count, if0.first_fail, if0.pass);
    end
    for (int i = 0; i < 10; i++) begin
      if (if0.done || if0.busy) seen_done = 1;
      tick();
    end
    n_tests++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: activity seen=%b required 0", seen_done);
    end
    run_u0(0, 4'b0000, 1'b0);
  endtask

  task automatic test_reset_midrun();
    sel0 = 0;
    flip0 = 4'b0001;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    repeat (2) tick(); // cycle 3: vector 1, one mismatch recorded
    n_tests++;
    if ({if0.vec_out, if0.err_count} !== {2'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL rstmid_pre: vec=%0d err=%0d required 1 1", if0.vec_out, if0.err_count);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if0.busy, if0.done, if0.pass, if0.err_count, if0.first_fail, if0.vec_out} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: busy=%b vec=%0d err=%0d required all zero",
               if0.busy, if0.vec_out, if0.err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({if0.busy, if0.done, if0.vec_out, if0.err_count} !== '0) begin
        n_fail++;
        $display("FAIL rstmid_idle i=%0d: busy=%b vec=%0d err=%0d required idle",
                 i, if0.busy, if0.vec_out, if0.err_count);
      end
    end
  endtask

  task automatic test_start_ignored();
    run_u0(2, 4'b0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (if0.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL start_ignored_rerun i=%0d: busy=%b required 0", i, if0.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel0 = 0;
    flip0 = 4'b0000;
    if0.start = 1'b1;
    tick();            // cycle 1
    repeat (8) tick(); // cycle 9
    n_tests++;
    if (if0.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done1: got %b required 1", if0.done);
    end
    tick();            // cycle 10: the single idle cycle
    n_tests++;
    if ({if0.busy, if0.done, if0.vec_out} !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_gap: busy,done,vec=%b required 0000", {if0.busy, if0.done, if0.vec_out});
    end
    tick();            // cycle 11: second run vector 0
    if0.start = 1'b0;
    n_tests++;
    if ({if0.busy, if0.vec_out} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_restart: busy,vec=%b required 100", {if0.busy, if0.vec_out});
    end
    repeat (8) tick(); // cycle 19
    n_tests++;
    if ({if0.done, if0.pass} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_done2: done,pass=%b required 11", {if0.done, if0.pass});
    end
    repeat (2) tick();
    n_tests++;
    if (if0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: busy=%b required 0", if0.busy);
    end
  endtask

  task automatic test_saturate();
    int errs, first;
    bit ok;
    model(4, 16'(gate_test_pkg::TT_OR2), 16'h0000, 1, errs, first, ok);
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (8) tick(); // cycle 9
    n_tests++;
    if ({if1.done, if1.err_count, if1.first_fail, if1.pass} !== {1'b1, 1'(errs), 2'(first), ok}) begin
      n_fail++;
      $display("FAIL saturate: done=%b err=%0d first=%0d pass=%b required 1 %0d %0d %b",
               if1.done, if1.err_count, if1.first_fail, if1.pass, errs, first, ok);
    end
    n_tests++;
    if ({if1.err_count, if1.first_fail} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL saturate_fixed: err=%0d first=%0d required 1 1", if1.err_count, if1.first_fail);
    end
    tick();
  endtask

  // u2: three inputs, SETTLE=3, random faults on a parity gate.
  task automatic run_u2(input logic [7:0] flip);
    int errs, first;
    bit ok;
    logic [7:0] yv;
    flip2 = flip;
    for (int k = 0; k < 8; k++) yv[k] = ($countones(k) % 2 == 1) ^ flip[k];
    model(8, 16'(TRUTH2), 16'(yv), 8, errs, first, ok);
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      n_tests++;
      if ({if2.busy, if2.vec_out} !== {1'b1, 3'((c - 1) / 3)}) begin
        n_fail++;
        $display("FAIL u2_vec c=%0d: busy,vec=%b required %b", c,
                 {if2.busy, if2.vec_out}, {1'b1, 3'((c - 1) / 3)});
      end
      tick();
    end
    n_tests++;
    if ({if2.done, if2.pass, if2.err_count} !== {1'b1, ok, 8'(errs)}) begin
      n_fail++;
      $display("FAIL u2_result flip=%b: done=%b pass=%b err=%0d required 1 %b %0d",
               flip, if2.done, if2.pass, if2.err_count, ok, errs);
    end
    if (errs != 0) begin
      n_tests++;
      if (if2.first_fail !== 3'(first)) begin
        n_fail++;
        $display("FAIL u2_first flip=%b: got %0d required %0d", flip, if2.first_fail, first);
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] f0;
    logic [7:0] f2;
    for (int i = 0; i < 8; i++) begin
      f0 = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      run_u0(int'($urandom_range(0, 4)), f0, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) begin
      f2 = (i == 0) ? 8'h00 : 8'($urandom);
      run_u2(f2);
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_or_mismatch();
    test_abort();
    test_reset_midrun();
    test_start_ignored();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_exhaustive_tester.md
# gate_exhaustive_tester

Self-checking stimulus sequencer for small combinational gates such as 2-input AND, OR, XOR and NAND. On a start request it drives every input vector to the gate under test in ascending binary order. After a settle window it samples the gate output and compares it against a parameterised truth table. It then reports a pass/fail verdict, a mismatch count and the first failing vector. It sits directly upstream of the gate (feeding its inputs) and consumes the gate's output.

## Interface
Parameters:
- `N_IN`, default 2: number of gate inputs; `2**N_IN` vectors are applied (1..4 supported).
- `TRUTH`, default `4'b1000`: expected output per vector; bit k is the expected output for vector k (default = 2-input AND).
- `SETTLE`, default 2: cycles each vector is held (≥1); output sampled on the last edge of the window.
- `ERR_W`, default 8: width of the mismatch counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: run request; sampled only in IDLE.
- `abort`, in, 1: synchronous cancel of a run in progress.
- `y_in`, in, 1: output of the gate under test.
- `vec_out`, out, N_IN: gate inputs; bit N_IN-1 is A (MSB), bit 0 is the last input.
- `busy`, out, 1: high while vectors are being applied.
- `done`, out, 1: one-cycle pulse at normal completion.
- `pass`, out, 1: verdict of the last completed run.
- `err_count`, out, ERR_W: saturating mismatch count for the current/last run.
- `first_fail`, out, N_IN: index of the first mismatching vector; valid when `err_count != 0`.

## Operation
- **Reset values:** all outputs are 0 and the state is IDLE.
- **IDLE:**
  - `vec_out=0`, `busy=0`.
  - `start=1` → APPLY at idx=0; on that edge `err_count`, `first_fail` and `pass` are cleared.
- **APPLY:**
  - `vec_out=idx`, `busy=1`; the settle counter runs 0..SETTLE-1.
  - On the edge where settle==SETTLE-1, `y_in` is compared with `TRUTH[idx]`.
  - On a mismatch: if `err_count` is 0, `first_fail` is set to idx; then `err_count` increments, saturating at `2**ERR_W-1`.
  - If idx==`2**N_IN-1` the next state is DONE; otherwise idx increments and the settle counter resets.
- **DONE:**
  - `vec_out=0`, `busy=0`, `done=1`.
  - `pass` is registered as (`err_count`==0), including any mismatch from the final sample.
  - Next state is IDLE unconditionally.
- **abort:**
  - While in APPLY, `abort=1` → IDLE on the next edge; `vec_out=0`, `busy=0`, no `done`, `pass` stays 0.
  - `err_count` and `first_fail` hold their partial values.
  - `abort` has priority over the sample taken on the same edge.
- **start handling:** `start` is ignored in APPLY and DONE. If `start` is held high, runs repeat back to back with exactly one IDLE cycle between them.
- **Reset mid-run:** outputs clear immediately on `rst_n` low without waiting for a clock edge; the block restarts only on a new `start`.
- **Widths:**
  - idx is N_IN+1 bits internally, so the terminal compare cannot wrap.
  - The settle counter is `$clog2(SETTLE+1)` bits.

## Timing
- The `start` edge is edge 0.
- Vector k is visible during cycles `1+k*SETTLE` .. `(k+1)*SETTLE`.
- `done` is high in cycle `2**N_IN*SETTLE+1`. With the defaults: vectors 00, 01, 10, 11 are each held 2 cycles and `done` is in cycle 9.
- `pass` and `err_count` are valid from the `done` cycle and hold until the next accepted `start`.
- `y_in` must settle combinationally within SETTLE cycles. There is no input synchroniser; `y_in` is same-clock-domain.

## Structure
- Shared package `gate_test_pkg` holds:
  - the state enum (IDLE, APPLY, DONE);
  - truth-table constants `TT_AND2=4'b1000`, `TT_OR2=4'b1110`, `TT_XOR2=4'b0110`, `TT_NAND2=4'b0111`, `TT_NOR2=4'b0001`.
- No sub-module: one FSM plus two counters in a single module. The bench instantiates it alongside the existing gate-level gates.

## Test plan
1. AND gate, `TRUTH=TT_AND2`, `SETTLE=2`, one-cycle `start` → `vec_out` steps 00, 01, 10, 11 (2 cycles each); `done` in cycle 9; `pass=1`; `err_count=0`.
2. OR gate with `TRUTH=TT_AND2` → mismatches on vectors 1 and 2; `err_count=2`; `first_fail=1`; `pass=0`.
3. `abort` asserted while idx=2 → `busy=0` and `vec_out=0` next cycle; no `done` pulse; `pass=0`. A following `start` gives a clean run with `pass=1`.
4. `rst_n` pulled low mid-run (idx=1) → all outputs 0 immediately; after release, IDLE until `start`.
5. `start` pulsed during APPLY → ignored, run length unchanged. `start` held high → second run's first vector appears 2 cycles after `done`.
6. `ERR_W=1`, gate output stuck at 0, `TRUTH=TT_OR2` → 3 mismatches saturate to `err_count=1`; `first_fail=1`; `pass=0`.
